// File: rtl/seq_arith_unit.sv
// Self-sequenced arithmetic unit: add/sub in one step, Booth signed multiply and
// restoring unsigned divide over WIDTH iterations, result presented as {A,Q}.
module seq_arith_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int unsigned     CntW     = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);
  localparam logic [1:0]      OpAdd    = 2'b00;
  localparam logic [1:0]      OpSub    = 2'b01;
  localparam logic [1:0]      OpMul    = 2'b10;
  localparam logic [1:0]      OpDiv    = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [1:0]      r_op;
  logic [WIDTH:0]  r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic            r_q_m1;
  logic [CntW-1:0] r_cnt;
  logic            r_carry;
  logic            r_overflow;
  logic            r_dbz;

  logic            w_accept;
  logic            w_dbz_req;
  logic            w_last;
  logic [WIDTH:0]  w_sum;
  logic [WIDTH:0]  w_diff;
  logic [WIDTH:0]  w_m_ext;
  logic [WIDTH:0]  w_booth;
  logic [WIDTH:0]  w_div_sh;
  logic [WIDTH:0]  w_div_sub;
  logic            w_div_ge;
  logic            w_add_ovf;
  logic            w_sub_ovf;

  assign w_accept  = start && (r_state != StCalc);
  assign w_dbz_req = (op == OpDiv) && (b == '0);
  // add/sub finish on their first CALC edge; mul/div run WIDTH edges.
  assign w_last    = !r_op[1] || (r_cnt == LastIter);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StFinish: begin
        if (start) begin
          w_state_d = w_dbz_req ? StFinish : StCalc;
        end else begin
          w_state_d = StIdle;
        end
      end
      StCalc: begin
        if (w_last) begin
          w_state_d = StFinish;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_sum     = {1'b0, r_q} + {1'b0, r_m};
  assign w_diff    = {1'b0, r_q} - {1'b0, r_m};
  assign w_add_ovf = (r_q[WIDTH-1] == r_m[WIDTH-1]) && (w_sum[WIDTH-1] != r_q[WIDTH-1]);
  assign w_sub_ovf = (r_q[WIDTH-1] != r_m[WIDTH-1]) && (w_diff[WIDTH-1] != r_q[WIDTH-1]);

  // Extra accumulator bit keeps A - M representable when M = -2^(WIDTH-1).
  assign w_m_ext = {r_m[WIDTH-1], r_m};

  always_comb begin
    unique case ({r_q[0], r_q_m1})
      2'b01:   w_booth = r_acc + w_m_ext;
      2'b10:   w_booth = r_acc - w_m_ext;
      default: w_booth = r_acc;
    endcase
  end

  assign w_div_sh  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_m};
  assign w_div_sub = w_div_sh - {1'b0, r_m};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= OpAdd;
      r_acc      <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_q_m1     <= 1'b0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_op       <= op;
      r_m        <= b;
      r_q_m1     <= 1'b0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      if (w_dbz_req) begin
        r_acc <= {1'b0, a};
        r_q   <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_acc <= '0;
        r_q   <= a;
        r_dbz <= 1'b0;
      end
    end else if (r_state == StCalc) begin
      r_cnt <= r_cnt + CntW'(1);
      unique case (r_op)
        OpAdd: begin
          r_q        <= w_sum[WIDTH-1:0];
          r_carry    <= w_sum[WIDTH];
          r_overflow <= w_add_ovf;
        end
        OpSub: begin
          r_q        <= w_diff[WIDTH-1:0];
          r_carry    <= w_diff[WIDTH];
          r_overflow <= w_sub_ovf;
        end
        OpMul: begin
          r_acc  <= {w_booth[WIDTH], w_booth[WIDTH:1]};
          r_q    <= {w_booth[0], r_q[WIDTH-1:1]};
          r_q_m1 <= r_q[0];
        end
        default: begin
          r_acc <= w_div_ge ? w_div_sub : w_div_sh;
          r_q   <= {r_q[WIDTH-2:0], w_div_ge};
        end
      endcase
    end
  end

  always_comb begin
    busy        = (r_state == StCalc);
    done        = (r_state == StFinish);
    result      = {r_acc[WIDTH-1:0], r_q};
    carry       = r_carry;
    overflow    = r_overflow;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit at WIDTH=8 and WIDTH=16: directed literal cases plus
// random traffic compared every cycle against a transaction-level model.
module tb_seq_arith_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  tb_start = '0;
  logic [1:0]  tb_op [2];
  logic [31:0] tb_a [2];
  logic [31:0] tb_b [2];
  logic [1:0]  o_busy, o_done, o_c, o_v, o_z;
  logic [15:0] r8;
  logic [31:0] r16;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  seq_arith_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(tb_start[0]), .op(tb_op[0]),
    .a(tb_a[0][7:0]), .b(tb_b[0][7:0]), .busy(o_busy[0]), .done(o_done[0]),
    .result(r8), .carry(o_c[0]), .overflow(o_v[0]), .div_by_zero(o_z[0])
  );

  seq_arith_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(tb_start[1]), .op(tb_op[1]),
    .a(tb_a[1][15:0]), .b(tb_b[1][15:0]), .busy(o_busy[1]), .done(o_done[1]),
    .result(r16), .carry(o_c[1]), .overflow(o_v[1]), .div_by_zero(o_z[1])
  );

  function automatic logic [31:0] res_of(input int i);
    return (i == 0) ? {16'h0, r8} : r16;
  endfunction

  function automatic logic [31:0] msk(input int i);
    return (i == 0) ? 32'hFF : 32'hFFFF;
  endfunction

  // Plain-arithmetic reference for one operation at width w.
  function automatic exp_t model(input int w, input logic [1:0] o,
                                 input logic [31:0] x_in, input logic [31:0] y_in);
    exp_t   e;
    longint m, x, y, r, sx, sy;
    logic   sa, sb, sr;
    m  = (longint'(1) << w) - 1;
    x  = longint'(x_in) & m;
    y  = longint'(y_in) & m;
    sa = ((x >> (w - 1)) & 1) != 0;
    sb = ((y >> (w - 1)) & 1) != 0;
    sx = sa ? x - (m + 1) : x;
    sy = sb ? y - (m + 1) : y;
    e  = '0;
    case (o)
      2'b00: begin
        r     = x + y;
        e.res = 32'(r & m);
        e.c   = ((r >> w) & 1) != 0;
        sr    = ((r >> (w - 1)) & 1) != 0;
        e.v   = (sa == sb) && (sr != sa);
      end
      2'b01: begin
        r     = (x - y) & m;
        e.res = 32'(r);
        e.c   = x < y;
        sr    = ((r >> (w - 1)) & 1) != 0;
        e.v   = (sa != sb) && (sr != sa);
      end
      2'b10: begin
        r     = sx * sy;
        e.res = 32'(r & ((longint'(1) << (2 * w)) - 1));
      end
      default: begin
        if (y == 0) begin
          e.res = 32'((x << w) | m);
          e.z   = 1'b1;
        end else begin
          e.res = 32'(((x % y) << w) | (x / y));
        end
      end
    endcase
    return e;
  endfunction

  // Per-instance model: cycles left in CALC, done pulse, and expected outputs.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int W = (g == 0) ? 8 : 16;
    int   rem;
    logic dn;
    logic vld;
    exp_t e;
    exp_t pend;
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        rem  <= 0;
        dn   <= 1'b0;
        vld  <= 1'b1;
        e    <= '0;
        pend <= '0;
      end else if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          dn  <= 1'b1;
          vld <= 1'b1;
          e   <= pend;
        end
      end else if (tb_start[g]) begin
        if (tb_op[g] == 2'b11 && (tb_b[g] & msk(g)) == 32'h0) begin
          dn  <= 1'b1;
          vld <= 1'b1;
          e   <= model(W, tb_op[g], tb_a[g], tb_b[g]);
        end else begin
          dn   <= 1'b0;
          vld  <= 1'b0;
          pend <= model(W, tb_op[g], tb_a[g], tb_b[g]);
          rem  <= tb_op[g][1] ? W : 1;
        end
      end else begin
        dn <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s w%0d: got %0h, want %0h at %0t", nm, (i == 0) ? 8 : 16, act, exp,
               $time);
    end
  endtask

  task automatic cmp_inst(input int i, input int rem, input logic dn, input logic vld,
                          input exp_t e);
    chk("busy", i, longint'(o_busy[i]), longint'(rem > 0));
    chk("done", i, longint'(o_done[i]), longint'(dn));
    if (vld) begin
      chk("result", i, longint'(res_of(i)), longint'(e.res));
      chk("carry", i, longint'(o_c[i]), longint'(e.c));
      chk("overflow", i, longint'(o_v[i]), longint'(e.v));
      chk("div_by_zero", i, longint'(o_z[i]), longint'(e.z));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, g_model[0].rem, g_model[0].dn, g_model[0].vld, g_model[0].e);
    cmp_inst(1, g_model[1].rem, g_model[1].dn, g_model[1].vld, g_model[1].e);
  end

  task automatic scramble(input int i);
    tb_op[i] = 2'($urandom_range(0, 3));
    tb_a[i]  = $urandom & msk(i);
    tb_b[i]  = $urandom & msk(i);
  endtask

  task automatic issue(input int i, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    #1;
    tb_start[i] = 1'b1;
    tb_op[i]    = o;
    tb_a[i]     = x;
    tb_b[i]     = y;
    @(negedge clk);
    #1;
    tb_start[i] = 1'b0;
    scramble(i);
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (!o_done[i] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", i, longint'(o_done[i]), 1);
  endtask

  task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] res, input logic c,
                        input logic v, input logic z, input int lat);
    int n;
    issue(i, o, x, y);
    wait_done(i, n);
    chk("lit_latency", i, n, lat);
    chk("lit_result", i, longint'(res_of(i)), longint'(res));
    chk("lit_carry", i, longint'(o_c[i]), longint'(c));
    chk("lit_overflow", i, longint'(o_v[i]), longint'(v));
    chk("lit_dbz", i, longint'(o_z[i]), longint'(z));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      tb_op[i] = 2'b00;
      tb_a[i]  = 32'h0;
      tb_b[i]  = 32'h0;
    end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    run_op(0, 2'b00, 32'h7F, 32'h01, 32'h0080, 1'b0, 1'b1, 1'b0, 1);
    run_op(0, 2'b01, 32'h05, 32'h07, 32'h00FE, 1'b1, 1'b0, 1'b0, 1);
    run_op(0, 2'b10, 32'hFD, 32'h07, 32'hFFEB, 1'b0, 1'b0, 1'b0, 8);
    run_op(0, 2'b10, 32'h80, 32'h80, 32'h4000, 1'b0, 1'b0, 1'b0, 8);
    run_op(0, 2'b11, 32'd200, 32'd7, 32'h041C, 1'b0, 1'b0, 1'b0, 8);
    run_op(0, 2'b11, 32'h55, 32'h00, 32'h55FF, 1'b0, 1'b0, 1'b1, 0);
    run_op(1, 2'b10, 32'h8000, 32'h8000, 32'h40000000, 1'b0, 1'b0, 1'b0, 16);
    run_op(1, 2'b11, 32'hFFFF, 32'h0003, 32'h00005555, 1'b0, 1'b0, 1'b0, 16);

    // Start pulse mid-multiply must be ignored.
    issue(0, 2'b10, 32'hFD, 32'h07);
    repeat (3) @(negedge clk);
    #1;
    tb_start[0] = 1'b1;
    tb_op[0]    = 2'b10;
    tb_a[0]     = 32'h11;
    tb_b[0]     = 32'h22;
    @(negedge clk);
    #1;
    tb_start[0] = 1'b0;
    wait_done(0, n);
    chk("midstart_result", 0, longint'(res_of(0)), 32'hFFEB);

    // Start held through FINISH: second op accepted with no IDLE cycle.
    @(negedge clk);
    #1;
    tb_start[0] = 1'b1;
    tb_op[0]    = 2'b00;
    tb_a[0]     = 32'h01;
    tb_b[0]     = 32'h02;
    wait_done(0, n);
    chk("b2b_first", 0, longint'(res_of(0)), 32'h0003);
    tb_op[0] = 2'b01;
    tb_a[0]  = 32'h09;
    tb_b[0]  = 32'h04;
    @(negedge clk);
    #1;
    tb_start[0] = 1'b0;
    chk("b2b_busy", 0, longint'(o_busy[0]), 1);
    chk("b2b_done", 0, longint'(o_done[0]), 0);
    wait_done(0, n);
    chk("b2b_second", 0, longint'(res_of(0)), 32'h0005);

    // Asynchronous reset in the middle of a divide.
    issue(0, 2'b11, 32'd200, 32'd7);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 0, longint'(o_busy[0]), 0);
    chk("rst_done", 0, longint'(o_done[0]), 0);
    chk("rst_result", 0, longint'(res_of(0)), 0);
    chk("rst_flags", 0, longint'({o_c[0], o_v[0], o_z[0]}), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    run_op(0, 2'b00, 32'h03, 32'h04, 32'h0007, 1'b0, 1'b0, 1'b0, 1);

    repeat (3000) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        tb_start[i] = ($urandom_range(0, 2) == 0);
        tb_op[i]    = 2'($urandom_range(0, 3));
        tb_a[i]     = $urandom & msk(i);
        tb_b[i]     = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & msk(i));
      end
    end
    @(negedge clk);
    #1 tb_start = '0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
